// File: rtl/addsub5_seq_ctrl.sv
// Purpose: handshake/register stage around a 5-bit ripple add/subtract datapath with a running accumulator.
// Latency: 2 cycles from accept to res_valid (operand capture, then result capture). Optional clamp: ADDSUB_SAT_EN.
// Backpressure: one request in flight; in_ready low until the held result is taken via res_valid/res_ready.
module addsub5_seq_ctrl #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic             sub_q;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q;
    logic             res_cout_q, res_ovf_q, res_zero_q;
    logic [WIDTH-1:0] acc_d;

    logic             accept;
    logic [WIDTH-1:0] opa_sel;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             carry;
    logic             bx;
    logic             add_ovf;
    logic [WIDTH-1:0] final_sum;

    // in_ready is registered so it stays low throughout reset and rises one edge after release
    assign accept = in_valid && in_ready_q;

    // Operand A source: accumulator (or its cleared value when acc_clr coincides) or in_a
    always_comb begin
        opa_sel = in_a;
        if (in_acc) begin
            opa_sel = acc_clr ? ACC_INIT : acc_q;
        end
    end

    // Ripple-carry adder; subtract is A + ~B + 1 with En feeding the carry-in
    always_comb begin
        add_sum = '0;
        bx      = 1'b0;
        carry   = sub_q;
        for (int i = 0; i < WIDTH; i++) begin
            bx         = opb_q[i] ^ sub_q;
            add_sum[i] = opa_q[i] ^ bx ^ carry;
            carry      = (opa_q[i] & bx) | (opa_q[i] & carry) | (bx & carry);
        end
        add_cout = carry;
    end

    // Signed overflow: effective operands agree in sign but the raw sum does not
    assign add_ovf = (opa_q[WIDTH-1] == (opb_q[WIDTH-1] ^ sub_q)) &&
                     (add_sum[WIDTH-1] != opa_q[WIDTH-1]);

    // Result value seen by res_sum and the accumulator
`ifdef ADDSUB_SAT_EN
    always_comb begin
        final_sum = add_sum;
        if (add_ovf) begin
            final_sum = opa_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign final_sum = add_sum;
`endif

    // Next-state and result-valid control
    always_comb begin
        state_d     = state_q;
        res_valid_d = res_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d     = DONE;
                res_valid_d = 1'b1;
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Accumulator: load every result, clear takes priority
    always_comb begin
        acc_d = acc_q;
        if (state_q == CALC) begin
            acc_d = final_sum;
        end
        if (acc_clr) begin
            acc_d = ACC_INIT;
        end
    end

    // State, handshake and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            res_valid_q <= res_valid_d;
            acc_q       <= acc_d;
        end
    end

    // Operand capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q <= '0;
            opb_q <= '0;
            sub_q <= 1'b0;
        end else if (accept) begin
            opa_q <= opa_sel;
            opb_q <= in_b;
            sub_q <= in_sub;
        end
    end

    // Result capture on CALC->DONE; held until the next operation completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_zero_q <= 1'b0;
        end else if (state_q == CALC) begin
            res_sum_q  <= final_sum;
            res_cout_q <= add_cout;
            res_ovf_q  <= add_ovf;
            res_zero_q <= (final_sum == '0);
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_addsub5_seq_ctrl.sv
// Purpose: scoreboard bench for addsub5_seq_ctrl (default build; clamp model follows ADDSUB_SAT_EN).
// Latency: checks res_valid is low one cycle after accept and high after the second edge.
// Backpressure: holds res_ready low for several cycles and checks outputs and in_ready.
module tb_addsub5_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [4:0] in_a, in_b;
    logic       in_sub, in_acc, acc_clr;
    logic       res_valid, res_ready;
    logic [4:0] res_sum;
    logic       res_cout, res_ovf, res_zero;
    logic [4:0] acc_q;

    typedef struct {
        logic [4:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic [4:0] acc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] model_acc = 5'd0;

    always #5 clk = ~clk;

    addsub5_seq_ctrl #(.WIDTH(5), .ACC_INIT(5'd0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc), .acc_clr(acc_clr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero),
        .acc_q(acc_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic done with integers, not a bit-level adder
    function automatic exp_t model(input int a, input int b, input logic sub);
        exp_t e;
        int   sa, sb, r;
        sa = (a > 15) ? a - 32 : a;
        sb = (b > 15) ? b - 32 : b;
        r  = sub ? sa - sb : sa + sb;
        e.ovf = (r > 15) || (r < -16);
        if (sub) begin
            e.sum  = 5'((a - b + 32) % 32);
            e.cout = (a >= b);
        end else begin
            e.sum  = 5'((a + b) % 32);
            e.cout = ((a + b) > 31);
        end
`ifdef ADDSUB_SAT_EN
        if (e.ovf) e.sum = (r > 15) ? 5'd15 : 5'd16;
`endif
        e.zero = (e.sum == 5'd0);
        e.acc  = e.sum;
        return e;
    endfunction

    task automatic do_op(input int a, input int b, input logic sub, input logic use_acc,
                         input logic clr_acc, input logic clr_calc, input int hold,
                         input logic rst_mid);
        exp_t e, got;
        int   opa, wait_cnt;
        logic [4:0] held;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        opa = use_acc ? (clr_acc ? 0 : int'(model_acc)) : a;
        e = model(opa, b, sub);
        if (clr_calc) e.acc = 5'd0;
        sb_q.push_back(e);
        model_acc = e.acc;
        in_valid = 1'b1; in_a = 5'(a); in_b = 5'(b); in_sub = sub;
        in_acc = use_acc; acc_clr = clr_acc; res_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; acc_clr = clr_calc; in_a = 5'd31; in_b = 5'd31;
        chk("lat_early_valid", res_valid, 0);
        chk("calc_ready", in_ready, 0);
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mid_valid", res_valid, 0);
            chk("rst_mid_acc", acc_q, 0);
            chk("rst_mid_ready", in_ready, 0);
            void'(sb_q.pop_back());
            model_acc = 5'd0;
            acc_clr = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_rel_ready", in_ready, 1);
            chk("rst_rel_valid", res_valid, 0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc_clr = 1'b0;
        chk("lat_valid", res_valid, 1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        got = sb_q.pop_front();
        chk("sum", res_sum, got.sum);
        chk("cout", res_cout, got.cout);
        chk("ovf", res_ovf, got.ovf);
        chk("zero", res_zero, got.zero);
        chk("acc", acc_q, got.acc);
        held = res_sum;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_sum", res_sum, got.sum);
            chk("bp_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", res_valid, 0);
        chk("hs_ready", in_ready, 1);
        if (hold > 0) chk("bp_acc", acc_q, got.acc);
    endtask

    task automatic clear_acc();
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        model_acc = 5'd0;
        chk("clr_acc", acc_q, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        in_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_sum", res_sum, 0);
        chk("rst_flags", {res_cout, res_ovf, res_zero}, 0);
        chk("rst_acc", acc_q, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        //    a   b  sub acc clrA clrC hold rst
        do_op( 7,  5, 0,  0,  0,   0,   0,   0);
        do_op( 3,  5, 1,  0,  0,   0,   0,   0);
        do_op(10, 10, 1,  0,  0,   0,   0,   0);
        do_op(15,  1, 0,  0,  0,   0,   0,   0);
        do_op(16,  1, 1,  0,  0,   0,   0,   0);
        do_op(31,  1, 0,  0,  0,   0,   0,   0);
        clear_acc();
        do_op( 0,  4, 0,  1,  0,   0,   0,   0);
        do_op( 0,  4, 0,  1,  0,   0,   0,   0);
        do_op( 0,  4, 0,  1,  0,   0,   0,   0);
        do_op(29,  2, 0,  1,  1,   0,   0,   0);
        do_op( 9,  3, 0,  0,  0,   0,   3,   0);
        do_op( 5,  6, 0,  0,  0,   1,   0,   0);
        do_op(20, 13, 1,  0,  0,   0,   0,   0);
        do_op( 4,  4, 0,  0,  0,   0,   0,   1);
        do_op( 1,  2, 0,  0,  0,   0,   0,   0);
        do_op( 0,  6, 1,  1,  0,   0,   2,   0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
